// File: rtl/cam_to_tft_stream.sv
// Camera byte stream -> packed pixels -> FIFO -> 8080-style TFT write bus with programmable strobe timing.
// Optional feature macro: TFT_RAMWR_CMD_EN (issues RAMWR_CMD with rs=0 at each frame start).
module cam_to_tft_stream #(
  parameter int IN_W        = 8,
  parameter int PIX_W       = 16,
  parameter int FIFO_AW     = 4,
  parameter int WR_LOW_CYC  = 1,
  parameter int WR_HIGH_CYC = 1,
  parameter logic [PIX_W-1:0] RAMWR_CMD = PIX_W'(16'h2C)
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iDVAL,
  input  logic               iVSYNC,
  input  logic [IN_W-1:0]    iDATA,
  input  logic               iSWAP_RB,
  output logic               lcd2_cs,
  output logic               lcd2_wr,
  output logic               lcd2_rs,
  output logic               lcd2_rd,
  output logic               lcd2_reset,
  output logic [PIX_W-1:0]   lcd2_data,
  output logic               oOVF,
  output logic [FIFO_AW:0]   oLEVEL,
  output logic               oBUSY
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOW = 2'd1, S_HIGH = 2'd2} state_t;

  localparam logic [7:0] LOW_LAST  = 8'(WR_LOW_CYC - 1);
  localparam logic [7:0] HIGH_LAST = 8'(WR_HIGH_CYC - 1);

  state_t             state_r;
  logic [7:0]         cnt_r;
  logic               vsync_r;
  logic               frame_s;
  logic               done_s;
  logic [PIX_W-1:0]   pix_raw_s;
  logic [PIX_W-1:0]   pix_sw_s;
  logic [PIX_W-1:0]   pix_r;
  logic               pix_vld_r;
  logic [PIX_W-1:0]   mem_r [0:(2**FIFO_AW)-1];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic               full_s;
  logic               fifo_ne_s;
  logic               push_s;
  logic               push_ok_s;
  logic               pop_s;
  logic               cmd_pend_s;
  logic               can_start_s;
  logic               start_s;
  logic [PIX_W-1:0]   load_data_s;

  assign lcd2_rd    = 1'b1;
  assign lcd2_reset = 1'b1;
  assign frame_s    = iVSYNC & ~vsync_r;

  // Frame-start edge detector reference
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) vsync_r <= 1'b0;
    else       vsync_r <= iVSYNC;
  end

  generate
    if (PIX_W == 2 * IN_W) begin : g_pack2
      logic            phase_r;
      logic [IN_W-1:0] byte_r;
      // A frame start forces the current byte to be treated as the first half of a pixel
      assign done_s    = iDVAL & phase_r & ~frame_s;
      assign pix_raw_s = {byte_r, iDATA};
      // Two-byte packer: phase 0 stores the MSB part, phase 1 completes the pixel
      always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
          phase_r <= 1'b0;
          byte_r  <= {IN_W{1'b0}};
        end else if (iDVAL) begin
          if (frame_s || !phase_r) begin
            byte_r  <= iDATA;
            phase_r <= 1'b1;
          end else begin
            phase_r <= 1'b0;
          end
        end else if (frame_s) begin
          phase_r <= 1'b0;
        end
      end
    end else begin : g_pack1
      assign done_s    = iDVAL;
      assign pix_raw_s = PIX_W'(iDATA);
    end

    if (PIX_W == 16) begin : g_swap
      assign pix_sw_s = iSWAP_RB ? {pix_raw_s[4:0], pix_raw_s[10:5], pix_raw_s[15:11]} : pix_raw_s;
    end else begin : g_noswap
      assign pix_sw_s = pix_raw_s;
    end
  endgenerate

  // Completed pixel stage, pushed into the FIFO on the following edge
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pix_vld_r <= 1'b0;
      pix_r     <= {PIX_W{1'b0}};
    end else begin
      pix_vld_r <= done_s;
      pix_r     <= pix_sw_s;
    end
  end

  // The top level bit of the count is set only when exactly full
  assign full_s    = oLEVEL[FIFO_AW];
  assign fifo_ne_s = (oLEVEL != {(FIFO_AW+1){1'b0}}) & ~frame_s;
  assign push_s    = pix_vld_r & ~frame_s;
  assign push_ok_s = push_s & (~full_s | pop_s);

`ifdef TFT_RAMWR_CMD_EN
  logic cmd_pend_r;
  assign cmd_pend_s = cmd_pend_r;
  // Memory-write command request, raised per frame and retired when the command strobe starts
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)                    cmd_pend_r <= 1'b0;
    else if (frame_s)             cmd_pend_r <= 1'b1;
    else if (start_s)             cmd_pend_r <= 1'b0;
    else                          cmd_pend_r <= cmd_pend_r;
  end
`else
  assign cmd_pend_s = 1'b0;
`endif

  // A new write may start from IDLE or on the last HIGH cycle, giving back-to-back strobes
  assign can_start_s = (state_r == S_IDLE) | ((state_r == S_HIGH) & (cnt_r == HIGH_LAST));
  assign start_s     = can_start_s & (cmd_pend_s | fifo_ne_s);
  assign pop_s       = start_s & ~cmd_pend_s;
  assign load_data_s = cmd_pend_s ? RAMWR_CMD : mem_r[rd_ptr_r];

  // FIFO storage
  always_ff @(posedge iCLK) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= pix_r;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      oLEVEL   <= {(FIFO_AW+1){1'b0}};
      oOVF     <= 1'b0;
    end else if (frame_s) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      oLEVEL   <= {(FIFO_AW+1){1'b0}};
      oOVF     <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + FIFO_AW'(1'b1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
      if (push_s && full_s && !pop_s) oOVF <= 1'b1;
      case ({push_ok_s, pop_s})
        2'b10:   oLEVEL <= oLEVEL + {{FIFO_AW{1'b0}}, 1'b1};
        2'b01:   oLEVEL <= oLEVEL - {{FIFO_AW{1'b0}}, 1'b1};
        default: oLEVEL <= oLEVEL;
      endcase
    end
  end

  // Write strobe FSM with registered bus outputs
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_r   <= S_IDLE;
      cnt_r     <= 8'd0;
      lcd2_cs   <= 1'b1;
      lcd2_wr   <= 1'b1;
      lcd2_rs   <= 1'b1;
      lcd2_data <= {PIX_W{1'b0}};
      oBUSY     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            state_r   <= S_LOW;
            cnt_r     <= 8'd0;
            lcd2_cs   <= 1'b0;
            lcd2_wr   <= 1'b0;
            lcd2_rs   <= ~cmd_pend_s;
            lcd2_data <= load_data_s;
            oBUSY     <= 1'b1;
          end
        end
        S_LOW: begin
          if (cnt_r == LOW_LAST) begin
            state_r <= S_HIGH;
            cnt_r   <= 8'd0;
            lcd2_wr <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        S_HIGH: begin
          if (cnt_r == HIGH_LAST) begin
            cnt_r <= 8'd0;
            if (start_s) begin
              state_r   <= S_LOW;
              lcd2_wr   <= 1'b0;
              lcd2_rs   <= ~cmd_pend_s;
              lcd2_data <= load_data_s;
            end else begin
              state_r <= S_IDLE;
              lcd2_cs <= 1'b1;
              oBUSY   <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 8'd0;
          lcd2_cs <= 1'b1;
          lcd2_wr <= 1'b1;
          oBUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_to_tft_stream.sv
// Directed self-checking bench for cam_to_tft_stream (small FIFO and stretched strobe to reach overflow).
module tb_cam_to_tft_stream;
  localparam int FIFO_AW = 2;

  logic iCLK = 1'b0, iRST = 1'b0, iDVAL = 1'b0, iVSYNC = 1'b0, iSWAP_RB = 1'b0;
  logic [7:0] iDATA = 8'h00;
  logic lcd2_cs, lcd2_wr, lcd2_rs, lcd2_rd, lcd2_reset, oOVF, oBUSY;
  logic [15:0] lcd2_data;
  logic [FIFO_AW:0] oLEVEL;
  int checks = 0;
  int errors = 0;

  cam_to_tft_stream #(.IN_W(8), .PIX_W(16), .FIFO_AW(FIFO_AW), .WR_LOW_CYC(2), .WR_HIGH_CYC(3),
                      .RAMWR_CMD(16'h002C)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iVSYNC(iVSYNC), .iDATA(iDATA), .iSWAP_RB(iSWAP_RB),
    .lcd2_cs(lcd2_cs), .lcd2_wr(lcd2_wr), .lcd2_rs(lcd2_rs), .lcd2_rd(lcd2_rd),
    .lcd2_reset(lcd2_reset), .lcd2_data(lcd2_data), .oOVF(oOVF), .oLEVEL(oLEVEL), .oBUSY(oBUSY));

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Waits for the next strobe, records its data/rs and how long wr stays low / high with cs low
  task automatic capture(output logic [15:0] d, output logic rs, output int low, output int high,
                         output bit ok);
    int n;
    n = 0; low = 0; high = 0; d = 16'h0000; rs = 1'b0; ok = 1'b1;
    while (lcd2_wr !== 1'b0 && n < 40) begin tick(); n++; end
    if (lcd2_wr !== 1'b0) ok = 1'b0;
    else begin
      d = lcd2_data; rs = lcd2_rs;
      while (lcd2_wr === 1'b0 && low < 40) begin low++; tick(); end
      while (lcd2_wr === 1'b1 && lcd2_cs === 1'b0 && high < 40) begin high++; tick(); end
    end
  endtask

  task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1);
    iDVAL = 1'b1; iDATA = b0; tick();
    iDATA = b1; tick();
    iDVAL = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    tick(); tick();
    checks++; if ({lcd2_cs, lcd2_wr, lcd2_rs} !== 3'b111) begin errors++; $display("FAIL reset_ctl got %b exp 111", {lcd2_cs, lcd2_wr, lcd2_rs}); end
    checks++; if (lcd2_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", lcd2_data); end
    checks++; if ({oLEVEL, oOVF, oBUSY} !== 5'b00000) begin errors++; $display("FAIL reset_status got %b exp 00000", {oLEVEL, oOVF, oBUSY}); end
    checks++; if ({lcd2_rd, lcd2_reset} !== 2'b11) begin errors++; $display("FAIL reset_const got %b exp 11", {lcd2_rd, lcd2_reset}); end
    @(negedge iCLK); iRST = 1'b1;
    tick(); tick();
  endtask

  task automatic test_packing();
    logic [15:0] d; logic rs; int lo, hi; bit ok;
    iSWAP_RB = 1'b0;
    send_pixel(8'hF8, 8'h1F);
    checks++; if (lcd2_wr !== 1'b1) begin errors++; $display("FAIL pack_lat0 got wr=%b exp 1", lcd2_wr); end
    tick();
    checks++; if (lcd2_wr !== 1'b1 || oLEVEL !== 3'd1) begin errors++; $display("FAIL pack_lat1 got wr=%b lvl=%0d exp wr=1 lvl=1", lcd2_wr, oLEVEL); end
    tick();
    checks++; if ({lcd2_cs, lcd2_wr, lcd2_rs, oBUSY} !== 4'b0011) begin errors++; $display("FAIL pack_lat2 got cs/wr/rs/busy=%b exp 0011", {lcd2_cs, lcd2_wr, lcd2_rs, oBUSY}); end
    capture(d, rs, lo, hi, ok);
    checks++; if (!ok || d !== 16'hF81F || rs !== 1'b1) begin errors++; $display("FAIL pack_data got %h rs=%b exp F81F rs=1", d, rs); end
    checks++; if (lo !== 2 || hi !== 3) begin errors++; $display("FAIL pack_timing got low=%0d high=%0d exp 2/3", lo, hi); end
    checks++; if (lcd2_cs !== 1'b1 || oBUSY !== 1'b0 || oLEVEL !== 3'd0) begin errors++; $display("FAIL pack_idle got cs=%b busy=%b lvl=%0d exp 1/0/0", lcd2_cs, oBUSY, oLEVEL); end
  endtask

  task automatic test_swap();
    logic [15:0] d; logic rs; int lo, hi; bit ok;
    iDVAL = 1'b1; iSWAP_RB = 1'b0; iDATA = 8'hF8; tick();
    iSWAP_RB = 1'b1; iDATA = 8'h00; tick();
    iDVAL = 1'b0; iSWAP_RB = 1'b0;
    capture(d, rs, lo, hi, ok);
    checks++; if (!ok || d !== 16'h001F) begin errors++; $display("FAIL swap_red got %h exp 001F", d); end
    iSWAP_RB = 1'b1;
    send_pixel(8'h12, 8'h34);
    iSWAP_RB = 1'b0;
    capture(d, rs, lo, hi, ok);
    checks++; if (!ok || d !== 16'hA222) begin errors++; $display("FAIL swap_mix got %h exp A222", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic rs; int lo, hi; bit ok;
    send_pixel(8'h01, 8'h02);
    iDVAL = 1'b1; iDATA = 8'h03; tick(); iDATA = 8'h04; tick(); iDVAL = 1'b0;
    capture(d, rs, lo, hi, ok);
    checks++; if (!ok || d !== 16'h0102 || lo !== 2 || hi !== 3) begin errors++; $display("FAIL b2b_first got %h low=%0d high=%0d exp 0102 2/3", d, lo, hi); end
    checks++; if (lcd2_wr !== 1'b0) begin errors++; $display("FAIL b2b_gap got wr=%b exp 0 (no idle gap)", lcd2_wr); end
    capture(d, rs, lo, hi, ok);
    checks++; if (!ok || d !== 16'h0304 || lo !== 2) begin errors++; $display("FAIL b2b_second got %h low=%0d exp 0304 2", d, lo); end
  endtask

  task automatic test_overflow();
    int run, bad, maxlvl;
    run = 0; bad = 0; maxlvl = 0;
    for (int k = 0; k < 40; k++) begin
      iDVAL = 1'b1; iDATA = 8'(k); tick();
      if (int'(oLEVEL) > maxlvl) maxlvl = int'(oLEVEL);
      if (lcd2_wr === 1'b0) run++; else begin if (run != 0 && run != 2) bad++; run = 0; end
    end
    iDVAL = 1'b0; tick();
    if (lcd2_wr === 1'b0) run++; else begin if (run != 0 && run != 2) bad++; run = 0; end
    checks++; if (oOVF !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", oOVF); end
    checks++; if (oLEVEL !== 3'd4 || maxlvl > 4) begin errors++; $display("FAIL ovf_level got %0d max=%0d exp 4 max<=4", oLEVEL, maxlvl); end
    iVSYNC = 1'b1; tick();
    if (lcd2_wr === 1'b0) run++; else begin if (run != 0 && run != 2) bad++; run = 0; end
    checks++; if (oOVF !== 1'b0 || oLEVEL !== 3'd0) begin errors++; $display("FAIL ovf_flush got ovf=%b lvl=%0d exp 0/0", oOVF, oLEVEL); end
    iVSYNC = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (lcd2_wr === 1'b0) run++; else begin if (run != 0 && run != 2) bad++; run = 0; end
    end
    checks++; if (bad !== 0 || oBUSY !== 1'b0) begin errors++; $display("FAIL ovf_strobe got bad_pulses=%0d busy=%b exp 0/0", bad, oBUSY); end
  endtask

  task automatic test_frame_mid_pixel();
    logic [15:0] d; logic rs; int lo, hi, extra; bit ok;
    iDVAL = 1'b1; iDATA = 8'hAA; tick();
    iVSYNC = 1'b1; iDATA = 8'h12; tick();
    iDATA = 8'h34; tick();
    iDVAL = 1'b0; iVSYNC = 1'b0;
`ifdef TFT_RAMWR_CMD_EN
    capture(d, rs, lo, hi, ok);
    checks++; if (!ok || d !== 16'h002C || rs !== 1'b0) begin errors++; $display("FAIL mid_cmd got %h rs=%b exp 002C rs=0", d, rs); end
`endif
    capture(d, rs, lo, hi, ok);
    checks++; if (!ok || d !== 16'h1234 || rs !== 1'b1) begin errors++; $display("FAIL mid_pixel got %h rs=%b exp 1234 rs=1", d, rs); end
    extra = 0;
    for (int k = 0; k < 15; k++) begin tick(); if (lcd2_wr !== 1'b1) extra++; end
    checks++; if (extra !== 0 || oLEVEL !== 3'd0) begin errors++; $display("FAIL mid_extra got wr_low_cycles=%0d lvl=%0d exp 0/0", extra, oLEVEL); end
  endtask

  task automatic test_frame_cmd();
    logic [15:0] d; logic rs; int lo, hi; bit ok;
    iVSYNC = 1'b1; tick(); iVSYNC = 1'b0;
    send_pixel(8'h55, 8'hAA);
`ifdef TFT_RAMWR_CMD_EN
    capture(d, rs, lo, hi, ok);
    checks++; if (!ok || d !== 16'h002C || rs !== 1'b0 || lo !== 2 || hi !== 3) begin errors++; $display("FAIL cmd_write got %h rs=%b low=%0d high=%0d exp 002C rs=0 2/3", d, rs, lo, hi); end
`endif
    capture(d, rs, lo, hi, ok);
    checks++; if (!ok || d !== 16'h55AA || rs !== 1'b1 || lo !== 2) begin errors++; $display("FAIL cmd_pixel got %h rs=%b low=%0d exp 55AA rs=1 2", d, rs, lo); end
  endtask

  task automatic test_reset_mid_write();
    int n;
    n = 0;
    send_pixel(8'h9A, 8'hBC);
    while (lcd2_wr !== 1'b0 && n < 20) begin tick(); n++; end
    checks++; if (lcd2_wr !== 1'b0) begin errors++; $display("FAIL rstmid_start got wr=%b exp 0", lcd2_wr); end
    #2 iRST = 1'b0;
    #1;
    checks++; if ({lcd2_cs, lcd2_wr, lcd2_rs, oBUSY} !== 4'b1110 || lcd2_data !== 16'h0000) begin errors++; $display("FAIL rstmid_async got cs/wr/rs/busy=%b data=%h exp 1110 0000", {lcd2_cs, lcd2_wr, lcd2_rs, oBUSY}, lcd2_data); end
    @(negedge iCLK); iRST = 1'b1;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_packing();
    test_swap();
    test_back_to_back();
    test_overflow();
    test_frame_mid_pixel();
    test_frame_cmd();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
